uart_tx_sched: RTL and testbench

//  Shares one UART_TX transmitter among N_REQ byte producers. Round-robin arbitration

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_sched.sv | 119 +++++++++++
 tb/tb_uart_tx_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: scheduler state encoding and per-frame configuration.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, LAUNCH, ACTIVE, DRAIN, ABORT} sched_state_t;

    typedef struct packed {
        logic       d_num;
        logic       s_num;
        logic [1:0] par;
    } uart_cfg_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam int         GID_W    = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [GID_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [GID_W-1:0] grant_idx,
    output logic             any
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = GID_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART_TX among N_REQ byte producers.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int LAUNCH_TO = 4096
) (
    input  logic               tick,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ*4-1:0] req_cfg,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   req_done,
    output logic [N_REQ-1:0]   req_err,
    output logic               send,
    output logic [7:0]         data_in,
    output logic               d_num,
    output logic               s_num,
    output logic [1:0]         par,
    input  logic               tx_active,
    input  logic               tx_done,
    output logic               busy,
    output logic [2:0]         grant_id
);

    localparam int CNT_W = $clog2(LAUNCH_TO);

    logic [N_REQ-1:0][7:0] data_arr;
    uart_cfg_t [N_REQ-1:0] cfg_arr;
    assign data_arr = req_data;
    assign cfg_arr  = req_cfg;

    sched_state_t     state, nxt;
    logic [GID_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    uart_cfg_t        cfg_q;
    logic [N_REQ-1:0] gnt_oh, gid_oh, done_d;
    logic [GID_W-1:0] gnt_idx;
    logic             gnt_any, send_d;
    logic [7:0]       sel_data;
    uart_cfg_t        sel_cfg;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (gnt_oh),
        .grant_idx(gnt_idx),
        .any      (gnt_any)
    );

    always_comb begin
        sel_data = '0;
        sel_cfg  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_data = data_arr[i];
                sel_cfg  = cfg_arr[i];
            end
        end
    end

    always_ff @(posedge tick) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // The timeout only counts cycles in which send is actually presented.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (gnt_any) nxt = LAUNCH;
            LAUNCH:  if (tx_active) nxt = ACTIVE;
                     else if (send && cnt == CNT_W'(LAUNCH_TO - 1)) nxt = ABORT;
            ACTIVE:  if (tx_done || !tx_active) nxt = DRAIN;
            DRAIN:   if (!tx_active) nxt = IDLE;
            ABORT:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) gid_oh[i] = (grant_id == GID_W'(i));
        busy    = (state != IDLE);
        req_err = (state == ABORT) ? gid_oh : '0;
        send_d  = (state == LAUNCH) && (nxt == LAUNCH);
        done_d  = (state == DRAIN && !tx_active) ? gid_oh : '0;
    end

    always_ff @(posedge tick) begin
        if (reset) begin
            send      <= 1'b0;
            req_ready <= '0;
            req_done  <= '0;
            data_in   <= 8'h00;
            cfg_q     <= '{d_num: 1'b0, s_num: 1'b0, par: PAR_NONE};
            grant_id  <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            send      <= send_d;
            req_done  <= done_d;
            req_ready <= '0;
            cnt       <= (state == LAUNCH && send) ? cnt + 1'b1 : '0;
            if (state == IDLE && gnt_any) begin
                req_ready <= gnt_oh;
                data_in   <= sel_data;
                cfg_q     <= sel_cfg;
                grant_id  <= gnt_idx;
                ptr       <= (gnt_idx == GID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign d_num = cfg_q.d_num;
    assign s_num = cfg_q.s_num;
    assign par   = cfg_q.par;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a behavioural UART_TX stand-in.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           tick = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N*4-1:0] req_cfg = '0;
    logic [N-1:0]   req_ready, req_done, req_err;
    logic           send, d_num, s_num, busy;
    logic [7:0]     data_in;
    logic [1:0]     par;
    logic [2:0]     grant_id;
    logic           tx_active = 1'b0;
    logic           tx_done = 1'b0;

    uart_tx_sched #(.N_REQ(N), .LAUNCH_TO(TO)) dut (
        .tick(tick), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_cfg(req_cfg),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .send(send), .data_in(data_in), .d_num(d_num), .s_num(s_num), .par(par),
        .tx_active(tx_active), .tx_done(tx_done),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 tick = ~tick;

    typedef struct {
        int         kind;   // 0 ready, 1 done, 2 err
        int         id;
        logic [7:0] data;
        logic [3:0] cfg;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    logic        mdl_en = 1'b1;
    logic        mdl_busy = 1'b0;
    int          mdl_idx = 0;
    int          mdl_nbits = 0;
    logic [15:0] mdl_frame = '0;
    logic [7:0]  mdl_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm, input string why);
        tests++;
        fails++;
        $display("FAIL %s: %s", nm, why);
    endtask

    task automatic push(input int kind, input int id, input logic [7:0] d, input logic [3:0] c);
        ev_t e;
        e.kind = kind; e.id = id; e.data = d; e.cfg = c;
        exp_q.push_back(e);
    endtask

    task automatic step;
        @(negedge tick);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        step;
        while ((busy || mdl_busy || exp_q.size() != 0) && n < budget) begin
            step;
            n++;
        end
        chk({nm, "_complete"}, n < budget, 1);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // UART_TX stand-in: one line bit per tick, tx_done pulses with tx_active fall.
    initial begin
        int nb;
        forever begin
            @(negedge tick);
            tx_done = 1'b0;
            if (reset) begin
                mdl_busy  = 1'b0;
                tx_active = 1'b0;
            end else if (!mdl_busy) begin
                if (send && mdl_en) begin
                    mdl_data  = data_in;
                    mdl_frame = '0;
                    nb = 1;
                    for (int i = 0; i < (d_num ? 8 : 7); i++) begin
                        mdl_frame[nb] = data_in[i];
                        nb++;
                    end
                    if (par == 2'b01 || par == 2'b10) begin
                        mdl_frame[nb] = (^data_in) ^ (par == 2'b01);
                        nb++;
                    end
                    mdl_frame[nb] = 1'b1;
                    nb++;
                    if (s_num) begin
                        mdl_frame[nb] = 1'b1;
                        nb++;
                    end
                    mdl_nbits = nb;
                    mdl_idx   = 0;
                    mdl_busy  = 1'b1;
                    tx_active = 1'b1;
                end
            end else begin
                if (send) bad("send_overlap", "send high while tx_active still high");
                mdl_idx++;
                if (mdl_idx >= mdl_nbits) begin
                    tx_active = 1'b0;
                    tx_done   = 1'b1;
                    mdl_busy  = 1'b0;
                end
            end
        end
    end

    // Monitor: every ready/done/err pulse is matched against the head of the queue.
    initial begin
        ev_t e;
        int  kind, id;
        forever begin
            step;
            if ((req_ready | req_done | req_err) != '0) begin
                chk("evt_onehot", $countones({req_ready, req_done, req_err}), 1);
                if (req_ready != '0) begin
                    kind = 0; id = oh_idx(req_ready);
                end else if (req_done != '0) begin
                    kind = 1; id = oh_idx(req_done);
                end else begin
                    kind = 2; id = oh_idx(req_err);
                end
                if (exp_q.size() == 0) begin
                    bad("unexpected_evt", $sformatf("got kind %0d id %0d, expected nothing", kind, id));
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_kind", kind, e.kind);
                    chk("evt_id", id, e.id);
                    if (kind == 0) begin
                        chk("ready_data", data_in, e.data);
                        chk("ready_cfg", {d_num, s_num, par}, e.cfg);
                    end
                    if (kind == 1) chk("done_data", mdl_data, e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses, rdy, cyc, fall, rise, badc, sc;
        logic [N-1:0] rv;
        logic prev_txa, prev_send, got;

        repeat (3) @(posedge tick);
        step;
        chk("rst_send", send, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", req_done, 0);
        chk("rst_err", req_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_in, 8'h00);
        chk("rst_cfg", {d_num, s_num, par}, 0);
        chk("rst_gid", grant_id, 0);
        reset = 1'b0;
        step;

        // Single request, latency and serial frame
        req_data[7:0] = 8'hA5; req_cfg[3:0] = 4'b1000;
        push(0, 0, 8'hA5, 4'b1000); push(1, 0, 8'hA5, 4'b1000);
        req_valid = 4'b0001;
        step;
        chk("t1_ready_lat", req_ready, 4'b0001);
        chk("t1_send_early", send, 0);
        req_valid = '0;
        step;
        chk("t1_send_lat", send, 1);
        chk("t1_busy", busy, 1);
        wait_idle(200, "t1");
        chk("t1_nbits", mdl_nbits, 10);
        chk("t1_frame", mdl_frame, 16'h034A);

        // Reset while ACTIVE
        req_data[15:8] = 8'hE1; req_cfg[7:4] = 4'b1000;
        push(0, 1, 8'hE1, 4'b1000);
        req_valid = 4'b0010;
        n = 0;
        do begin
            step;
            if (req_ready != '0) req_valid = '0;
            n++;
        end while (!tx_active && n < 50);
        chk("t5_active", tx_active, 1);
        step; step;
        chk("t5_busy_pre", busy, 1);
        chk("t5_gid_pre", grant_id, 1);
        reset = 1'b1;
        pulses = 0;
        repeat (3) begin
            step;
            if ((req_done | req_err) != '0) pulses++;
        end
        reset = 1'b0;
        chk("t5_pulses", pulses, 0);
        chk("t5_busy", busy, 0);
        chk("t5_send", send, 0);
        chk("t5_data", data_in, 8'h00);
        chk("t5_cfg", {d_num, s_num, par}, 0);
        chk("t5_gid", grant_id, 0);
        repeat (4) step;
        chk("t5_queue", exp_q.size(), 0);

        // Round-robin with all requesters valid; req 3 carries par=11
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_cfg  = {4'b1011, 4'b1000, 4'b1000, 4'b1000};
        for (int k = 0; k < 5; k++) begin
            push(0, k % 4, 8'(8'h10 + k % 4), (k % 4 == 3) ? 4'b1011 : 4'b1000);
            push(1, k % 4, 8'(8'h10 + k % 4), (k % 4 == 3) ? 4'b1011 : 4'b1000);
        end
        req_valid = 4'b1111;
        rdy = 0; n = 0;
        while (rdy < 5 && n < 500) begin
            step;
            n++;
            if (req_ready != '0) rdy++;
        end
        req_valid = '0;
        chk("t2_grants", rdy, 5);
        wait_idle(200, "t2");
        chk("t2_gid_wrap", grant_id, 0);

        // Back-to-back: req 1 then req 2
        req_data[15:8] = 8'h3C; req_data[23:16] = 8'hC3;
        req_cfg[7:4] = 4'b1000; req_cfg[11:8] = 4'b1000;
        push(0, 1, 8'h3C, 4'b1000); push(1, 1, 8'h3C, 4'b1000);
        push(0, 2, 8'hC3, 4'b1000); push(1, 2, 8'hC3, 4'b1000);
        rv = 4'b0110; req_valid = rv;
        cyc = 0; fall = -1; rise = -1; badc = 0;
        prev_txa = tx_active; prev_send = send;
        while (cyc < 400) begin
            step;
            cyc++;
            if (req_ready[1]) rv[1] = 1'b0;
            if (req_ready[2]) rv[2] = 1'b0;
            req_valid = rv;
            if (prev_txa && !tx_active && fall < 0) fall = cyc;
            if (!prev_send && send && fall >= 0 && rise < 0) rise = cyc;
            if (busy && grant_id == 3'd1 && data_in !== 8'h3C) badc++;
            prev_txa = tx_active; prev_send = send;
            if (rv == '0 && !busy && !mdl_busy && exp_q.size() == 0) break;
        end
        chk("t4_finished", cyc < 400, 1);
        chk("t4_gap", rise - fall, 4);
        chk("t4_data_stable", badc, 0);

        // Launch timeout with UART_TX never answering
        mdl_en = 1'b0;
        req_data[31:24] = 8'h77; req_cfg[15:12] = 4'b1000;
        push(0, 3, 8'h77, 4'b1000); push(2, 3, 8'h00, 4'b0000);
        req_valid = 4'b1000;
        sc = 0; n = 0; got = 1'b0;
        while (!got && n < 100) begin
            step;
            n++;
            if (req_ready != '0) req_valid = '0;
            if (send) sc++;
            if (req_err != '0) got = 1'b1;
        end
        chk("t3_err_seen", got, 1);
        chk("t3_err_id", req_err, 4'b1000);
        chk("t3_send_cycles", sc, TO);
        step;
        chk("t3_idle", busy, 0);
        chk("t3_send_off", send, 0);
        mdl_en = 1'b1;

        // Config pass-through on req 2
        req_data[23:16] = 8'h5A; req_cfg[11:8] = 4'b1101;
        push(0, 2, 8'h5A, 4'b1101); push(1, 2, 8'h5A, 4'b1101);
        req_valid = 4'b0100;
        n = 0;
        do begin
            step;
            if (req_ready != '0) req_valid = '0;
            n++;
        end while (!tx_active && n < 50);
        chk("t6_active", tx_active, 1);
        chk("t6_d_num", d_num, 1);
        chk("t6_s_num", s_num, 1);
        chk("t6_par", par, 2'b01);
        wait_idle(200, "t6");
        chk("t6_nbits", mdl_nbits, 12);

        repeat (3) step;
        chk("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
